stack_arith_unit: RTL and testbench
===================================

// Module: stack_arith_unit
// PURPOSE
//  Parametrised operand stack with integrated signed ALU, the execution core of the stack CPU.
//  Accepts one command per handshake: PUSH/POP/SWAP, or a binary op (ADD/SUB/MUL/DIV).
//  A binary op pops TOS (A) and NOS (B) and pushes A op B.
//  DIV is iterative (multi-cycle); all other commands complete at the accepting edge.
// PARAMETERS
//  WIDTH  8   data width, two's complement
//  DEPTH  16  stack entries (>=2)
//  CW     $clog2(DEPTH+1)  count width (localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      unit can accept; high except while DIV runs
//  cmd_op     in   3      000 NOP, 001 PUSH, 010 POP, 011 SWAP, 100 ADD, 101 SUB, 110 MUL, 111 DIV
//  cmd_data   in   WIDTH  PUSH operand
//  tos        out  WIDTH  stack[count-1]; 0 when empty
//  nos        out  WIDTH  stack[count-2]; 0 when count<2
//  count      out  CW     entries held, 0..DEPTH
//  empty      out  1      count==0
//  full       out  1      count==DEPTH
//  carry_out  out  1      unsigned carry (ADD) / borrow (SUB) of last arithmetic op
//  ovf        out  1      signed overflow of last arithmetic op
//  err        out  2      00 ok, 01 underflow, 10 overflow (push when full), 11 divide by zero
//  busy       out  1      DIV in progress
//  done       out  1      one-cycle pulse when any accepted command retires
// BEHAVIOUR
//  - Reset: count=0, all flags/err/busy/done=0, cmd_ready=1; stack contents are don't-care.
//  - Accept occurs on an edge with cmd_valid & cmd_ready.
//  - err, carry_out and ovf are updated on every accepted non-NOP command.
//    err holds until the next such command.
//  - PUSH: count<DEPTH -> write cmd_data, count+1; full -> err=10, no change.
//  - POP: count>=1 -> count-1; empty -> err=01.
//  - SWAP: needs count>=2, else err=01.
//  - Binary ops with count<2: err=01, stack unchanged.
//  - ADD/SUB: result = A+B / A-B, truncated to WIDTH.
//    carry_out = bit WIDTH of the unsigned sum/difference; ovf = signed overflow.
//  - MUL: signed 2WIDTH product, low WIDTH bits kept; ovf=1 if the product does not fit; carry_out=0.
//  - Completion of ADD/SUB/MUL/SWAP/PUSH/POP: result is visible on tos the cycle after the
//    accepting edge; done pulses that same cycle.
//  - DIV: signed, quotient truncated toward zero; remainder discarded.
//    B==0 -> err=11, stack unchanged, done next cycle, no busy.
//    A=MIN, B=-1 -> result MIN, ovf=1.
//  - DIV timing: the accepting edge latches operands, sets busy and drops cmd_ready.
//    WIDTH iteration cycles follow, then a writeback cycle: count-1, new tos = quotient, busy=0, done=1.
//    Total latency is WIDTH+1 cycles from accept to visible result.
//  - FSM states:
//    IDLE   -(DIV accepted, B!=0)-> DIV_RUN
//    DIV_RUN -(iteration counter==WIDTH-1)-> DIV_WB
//    DIV_WB -> IDLE
//  - Commands presented while busy are held by the producer (cmd_ready=0); nothing is lost.
//  - Reset mid-DIV aborts immediately to reset state; no partial writeback.
//  - NOP: no state change, no done pulse.
// STRUCTURE
//  - Shared package stack_cpu_pkg: opcode localparams, err codes, FSM state encoding.
//  - One sub-module: stack_seq_divider.
//    Signed restoring divider, WIDTH iterations.
//    Ports: clk, reset, start, dividend, divisor, quotient, busy, valid.
//  - Top level: stack RAM, count register, ALU datapath, control FSM.
// TESTING
//  1. PUSH 7, PUSH 2, ADD -> tos=9, count=1, carry_out=0, ovf=0, done one cycle after accept.
//  2. PUSH 2, PUSH 8, SUB -> tos=6; PUSH 6, PUSH 4, SUB -> tos=-2 (8'hFE), carry_out=1.
//  3. PUSH 9, PUSH 3, MUL -> tos=27 (8'h1B); PUSH -3, PUSH 6, MUL -> tos=-18; PUSH 16, PUSH 16, MUL -> ovf=1.
//  4. PUSH 27, PUSH 54, DIV -> busy WIDTH+1 cycles, then tos=2.
//     PUSH -2, PUSH 2, DIV -> tos=-1.
//     PUSH 0, PUSH 5, DIV -> err=11, count unchanged.
//  5. Fill DEPTH entries, PUSH again -> err=10, full=1.
//     Pop to empty, ADD -> err=01, count=0.
//  6. Assert reset 3 cycles into a DIV -> count=0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: opcodes, error codes and the
// control-FSM state encoding used by the arithmetic stack unit.
package stack_cpu_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_PUSH = 3'b001;
   localparam logic [2:0] OP_POP  = 3'b010;
   localparam logic [2:0] OP_SWAP = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_DIV  = 3'b111;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_UNDER = 2'b01;
   localparam logic [1:0] ERR_OVER  = 2'b10;
   localparam logic [1:0] ERR_DIV0  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIV_RUN = 2'd1,
      ST_DIV_WB  = 2'd2
   } state_t;

endpackage

// File: rtl/stack_seq_divider.sv
// Signed restoring divider: magnitudes are divided over WIDTH iterations and
// the quotient sign is applied on the output (truncation toward zero).
module stack_seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic             busy,
   output logic             valid
);

   localparam int IW = $clog2(WIDTH);

   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic             neg_reg;
   logic [IW-1:0]    iter_reg;
   logic             busy_reg;
   logic             valid_reg;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH+1:0] rem_shift;
   logic [WIDTH+1:0] trial;

   // Magnitude of MIN is representable as an unsigned WIDTH-bit value.
   assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

   assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
   assign trial     = rem_shift - {2'b00, dsr_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_reg   <= '0;
         quo_reg   <= '0;
         dsr_reg   <= '0;
         neg_reg   <= 1'b0;
         iter_reg  <= '0;
         busy_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         if (start && !busy_reg) begin
            rem_reg  <= '0;
            quo_reg  <= dividend_mag;
            dsr_reg  <= divisor_mag;
            neg_reg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            iter_reg <= '0;
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            if (trial[WIDTH+1]) begin
               rem_reg <= rem_shift[WIDTH:0];
               quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
            end else begin
               rem_reg <= trial[WIDTH:0];
               quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
            end
            iter_reg <= iter_reg + 1'b1;
            if (iter_reg == IW'(WIDTH - 1)) begin
               busy_reg  <= 1'b0;
               valid_reg <= 1'b1;
            end
         end
      end
   end

   assign quotient = neg_reg ? (~quo_reg + 1'b1) : quo_reg;
   assign busy     = busy_reg;
   assign valid    = valid_reg;

endmodule

// File: rtl/stack_arith_unit.sv
// Operand stack with integrated signed ALU; A is the top of stack, B the entry
// below it, and binary ops replace both with A op B.
module stack_arith_unit
   import stack_cpu_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 16,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             carry_out,
   output logic             ovf,
   output logic [1:0]       err,
   output logic             busy,
   output logic             done
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   // Stack storage is read combinationally so tos/nos track count directly.
   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [1:0]       err_reg, err_next;
   logic             carry_reg, carry_next;
   logic             ovf_reg, ovf_next;
   logic             done_reg, done_next;
   logic [IW-1:0]    iter_reg, iter_next;

   logic             wa_en, wb_en;
   logic [AW-1:0]    wa_idx, wb_idx;
   logic [WIDTH-1:0] wa_data, wb_data;

   logic [AW-1:0]    top_idx, sec_idx;
   logic [WIDTH-1:0] a_val, b_val;
   logic             has_two;
   logic [WIDTH:0]   sum_full, diff_full;
   logic signed [2*WIDTH-1:0] prod_full;
   logic             add_ovf, sub_ovf, mul_ovf;

   logic             div_start, div_busy, div_valid;
   logic [WIDTH-1:0] div_quotient;

   assign top_idx = count_reg[AW-1:0] - AW'(1);
   assign sec_idx = count_reg[AW-1:0] - AW'(2);
   assign a_val   = mem[top_idx];
   assign b_val   = mem[sec_idx];
   assign has_two = (count_reg >= CW'(2));

   assign sum_full  = {1'b0, a_val} + {1'b0, b_val};
   assign diff_full = {1'b0, a_val} - {1'b0, b_val};
   assign prod_full = $signed(a_val) * $signed(b_val);
   assign add_ovf   = (a_val[WIDTH-1] == b_val[WIDTH-1]) && (sum_full[WIDTH-1] != a_val[WIDTH-1]);
   assign sub_ovf   = (a_val[WIDTH-1] != b_val[WIDTH-1]) && (diff_full[WIDTH-1] != a_val[WIDTH-1]);
   assign mul_ovf   = (prod_full[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_full[WIDTH-1]}});

   stack_seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .dividend (a_val),
      .divisor  (b_val),
      .quotient (div_quotient),
      .busy     (div_busy),
      .valid    (div_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      err_next   = err_reg;
      carry_next = carry_reg;
      ovf_next   = ovf_reg;
      done_next  = 1'b0;
      iter_next  = iter_reg;
      cmd_ready  = 1'b0;
      div_start  = 1'b0;
      wa_en      = 1'b0;
      wa_idx     = sec_idx;
      wa_data    = a_val;
      wb_en      = 1'b0;
      wb_idx     = top_idx;
      wb_data    = b_val;

      case (state_reg)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_op != OP_NOP) begin
               done_next  = 1'b1;
               err_next   = ERR_OK;
               carry_next = 1'b0;
               ovf_next   = 1'b0;
               case (cmd_op)
                  OP_PUSH: begin
                     if (count_reg == CW'(DEPTH)) begin
                        err_next = ERR_OVER;
                     end else begin
                        wa_en      = 1'b1;
                        wa_idx     = count_reg[AW-1:0];
                        wa_data    = cmd_data;
                        count_next = count_reg + CW'(1);
                     end
                  end
                  OP_POP: begin
                     if (count_reg == '0) err_next = ERR_UNDER;
                     else                 count_next = count_reg - CW'(1);
                  end
                  OP_SWAP: begin
                     if (!has_two) begin
                        err_next = ERR_UNDER;
                     end else begin
                        wa_en = 1'b1;
                        wb_en = 1'b1;
                     end
                  end
                  OP_ADD, OP_SUB, OP_MUL: begin
                     if (!has_two) begin
                        err_next = ERR_UNDER;
                     end else begin
                        wa_en      = 1'b1;
                        count_next = count_reg - CW'(1);
                        if (cmd_op == OP_ADD) begin
                           wa_data    = sum_full[WIDTH-1:0];
                           carry_next = sum_full[WIDTH];
                           ovf_next   = add_ovf;
                        end else if (cmd_op == OP_SUB) begin
                           wa_data    = diff_full[WIDTH-1:0];
                           carry_next = diff_full[WIDTH];
                           ovf_next   = sub_ovf;
                        end else begin
                           wa_data  = prod_full[WIDTH-1:0];
                           ovf_next = mul_ovf;
                        end
                     end
                  end
                  OP_DIV: begin
                     if (!has_two) begin
                        err_next = ERR_UNDER;
                     end else if (b_val == '0) begin
                        err_next = ERR_DIV0;
                     end else begin
                        // The quotient retires later from DIV_WB.
                        div_start  = 1'b1;
                        done_next  = 1'b0;
                        ovf_next   = (a_val == MIN_VAL) && (b_val == '1);
                        iter_next  = '0;
                        state_next = ST_DIV_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_DIV_RUN: begin
            iter_next = iter_reg + 1'b1;
            if (iter_reg == IW'(WIDTH - 1)) state_next = ST_DIV_WB;
         end
         ST_DIV_WB: begin
            state_next = ST_IDLE;
            if (div_valid) begin
               wa_en      = 1'b1;
               wa_data    = div_quotient;
               count_next = count_reg - CW'(1);
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
         err_reg   <= ERR_OK;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         done_reg  <= 1'b0;
         iter_reg  <= '0;
      end else begin
         count_reg <= count_next;
         err_reg   <= err_next;
         carry_reg <= carry_next;
         ovf_reg   <= ovf_next;
         done_reg  <= done_next;
         iter_reg  <= iter_next;
      end
   end

   always_ff @(posedge clk) begin
      if (wa_en) mem[wa_idx] <= wa_data;
      if (wb_en) mem[wb_idx] <= wb_data;
   end

   assign tos       = (count_reg == '0) ? '0 : a_val;
   assign nos       = has_two ? b_val : '0;
   assign count     = count_reg;
   assign empty     = (count_reg == '0);
   assign full      = (count_reg == CW'(DEPTH));
   assign carry_out = carry_reg;
   assign ovf       = ovf_reg;
   assign err       = err_reg;
   assign busy      = div_busy | (state_reg != ST_IDLE);
   assign done      = done_reg;

endmodule

// File: tb/tb_stack_arith_unit.sv
// Directed bench for stack_arith_unit: each scenario drives commands and
// checks tos/count/flags against hand-computed values.
module tb_stack_arith_unit;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;

   localparam logic [2:0] NOP  = 3'b000;
   localparam logic [2:0] PUSH = 3'b001;
   localparam logic [2:0] POP  = 3'b010;
   localparam logic [2:0] SWAP = 3'b011;
   localparam logic [2:0] ADD  = 3'b100;
   localparam logic [2:0] SUB  = 3'b101;
   localparam logic [2:0] MUL  = 3'b110;
   localparam logic [2:0] DIV  = 3'b111;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = NOP;
   logic [WIDTH-1:0] cmd_data = '0;
   logic [WIDTH-1:0] tos, nos;
   logic [CW-1:0]    count;
   logic             empty, full, carry_out, ovf, busy, done;
   logic [1:0]       err;

   // {tos, count, carry_out, ovf, err, done}
   logic [17:0] obs;
   assign obs = {tos, count, carry_out, ovf, err, done};

   int pass_cnt  = 0;
   int check_cnt = 0;

   always #5 clk = ~clk;

   stack_arith_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .tos       (tos),
      .nos       (nos),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .carry_out (carry_out),
      .ovf       (ovf),
      .err       (err),
      .busy      (busy),
      .done      (done)
   );

   task automatic send(input logic [2:0] op, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
      $display("op=%0d data=%h -> tos=%h nos=%h count=%0d err=%0d c=%b v=%b done=%b busy=%b",
               op, d, tos, nos, count, err, carry_out, ovf, done, busy);
   endtask

   task automatic wait_div(output int lat);
      lat = 0;
      while (busy === 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      $display("div retired after %0d cycles -> tos=%h count=%0d err=%0d v=%b done=%b",
               lat, tos, count, err, ovf, done);
   endtask

   task automatic test_reset();
      check_cnt++;
      if ({count, empty, full, cmd_ready, busy, done, err, tos, nos} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00}) begin
         $display("FAIL reset: got cnt=%0d e=%b f=%b rdy=%b busy=%b done=%b err=%0d tos=%h nos=%h, want cnt=0 e=1 f=0 rdy=1 busy=0 done=0 err=0 tos=00 nos=00",
                  count, empty, full, cmd_ready, busy, done, err, tos, nos);
      end else pass_cnt++;
   endtask

   task automatic test_add();
      send(PUSH, 8'h07);
      send(PUSH, 8'h02);
      check_cnt++;
      if ({tos, nos} !== {8'h02, 8'h07}) $display("FAIL push_order: got tos/nos=%h want 0207", {tos, nos});
      else pass_cnt++;
      send(ADD, 8'h00);
      check_cnt++;
      if (obs !== {8'h09, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL add_7_2: got %h want %h", obs, {8'h09, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++;
      if ({tos, done} !== {8'h09, 1'b0}) $display("FAIL add_done_pulse: got tos=%h done=%b want tos=09 done=0", tos, done);
      else pass_cnt++;
      send(POP, 8'h00);
      send(PUSH, 8'hFF);
      send(PUSH, 8'h01);
      send(ADD, 8'h00);
      check_cnt++;
      if (obs !== {8'h00, 5'd1, 1'b1, 1'b0, 2'b00, 1'b1}) $display("FAIL add_carry: got %h want %h", obs, {8'h00, 5'd1, 1'b1, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_sub();
      send(PUSH, 8'h02);
      send(PUSH, 8'h08);
      send(SUB, 8'h00);
      check_cnt++;
      if (obs !== {8'h06, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL sub_8_2: got %h want %h", obs, {8'h06, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
      send(PUSH, 8'h06);
      send(PUSH, 8'h04);
      send(SUB, 8'h00);
      check_cnt++;
      if (obs !== {8'hFE, 5'd1, 1'b1, 1'b0, 2'b00, 1'b1}) $display("FAIL sub_borrow: got %h want %h", obs, {8'hFE, 5'd1, 1'b1, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
      send(PUSH, 8'h01);
      send(PUSH, 8'h80);
      send(SUB, 8'h00);
      check_cnt++;
      if (obs !== {8'h7F, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1}) $display("FAIL sub_ovf: got %h want %h", obs, {8'h7F, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_mul();
      send(PUSH, 8'h09);
      send(PUSH, 8'h03);
      send(MUL, 8'h00);
      check_cnt++;
      if (obs !== {8'h1B, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL mul_9_3: got %h want %h", obs, {8'h1B, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
      send(PUSH, 8'hFD);
      send(PUSH, 8'h06);
      send(MUL, 8'h00);
      check_cnt++;
      if (obs !== {8'hEE, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL mul_neg: got %h want %h", obs, {8'hEE, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
      send(PUSH, 8'h10);
      send(PUSH, 8'h10);
      send(MUL, 8'h00);
      check_cnt++;
      if (obs !== {8'h00, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1}) $display("FAIL mul_ovf: got %h want %h", obs, {8'h00, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_swap();
      send(PUSH, 8'h01);
      send(PUSH, 8'h02);
      send(SWAP, 8'h00);
      check_cnt++;
      if ({tos, nos, count, err, done} !== {8'h01, 8'h02, 5'd2, 2'b00, 1'b1})
         $display("FAIL swap: got tos=%h nos=%h cnt=%0d err=%0d done=%b want 01 02 2 0 1", tos, nos, count, err, done);
      else pass_cnt++;
      send(POP, 8'h00);
      send(SWAP, 8'h00);
      check_cnt++;
      if (obs !== {8'h02, 5'd1, 1'b0, 1'b0, 2'b01, 1'b1}) $display("FAIL swap_under: got %h want %h", obs, {8'h02, 5'd1, 1'b0, 1'b0, 2'b01, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_div();
      int lat;
      int held_bad;
      send(PUSH, 8'h1B);
      send(PUSH, 8'h36);
      // Present DIV, then keep a PUSH waiting while the divider runs.
      cmd_valid = 1'b1;
      cmd_op    = DIV;
      @(posedge clk); #1;
      cmd_op    = PUSH;
      cmd_data  = 8'h55;
      check_cnt++;
      if ({busy, cmd_ready} !== 2'b10) $display("FAIL div_start: got busy=%b rdy=%b want busy=1 rdy=0", busy, cmd_ready);
      else pass_cnt++;
      lat = 0;
      held_bad = 0;
      while (busy === 1'b1 && lat < 40) begin
         if (count !== 5'd2 || done !== 1'b0 || cmd_ready !== 1'b0) held_bad++;
         @(posedge clk); #1;
         lat++;
      end
      $display("div 54/27 retired after %0d cycles -> tos=%h count=%0d done=%b", lat, tos, count, done);
      check_cnt++;
      if (lat !== WIDTH + 1) $display("FAIL div_latency: got %0d cycles want %0d", lat, WIDTH + 1);
      else pass_cnt++;
      check_cnt++;
      if (held_bad !== 0) $display("FAIL div_busy_state: got %0d bad busy cycles want 0", held_bad);
      else pass_cnt++;
      check_cnt++;
      if (obs !== {8'h02, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL div_54_27: got %h want %h", obs, {8'h02, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
      check_cnt++;
      if ({tos, nos, count} !== {8'h55, 8'h02, 5'd2}) $display("FAIL div_held_push: got tos=%h nos=%h cnt=%0d want 55 02 2", tos, nos, count);
      else pass_cnt++;
      send(POP, 8'h00);
      send(POP, 8'h00);

      send(PUSH, 8'hFE);
      send(PUSH, 8'h02);
      send(DIV, 8'h00);
      wait_div(lat);
      check_cnt++;
      if ({lat[7:0], obs} !== {8'd9, 8'hFF, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL div_neg: got lat=%0d obs=%h want lat=9 obs=%h", lat, obs, {8'hFF, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);

      send(PUSH, 8'h00);
      send(PUSH, 8'h05);
      send(DIV, 8'h00);
      check_cnt++;
      if ({busy, obs} !== {1'b0, 8'h05, 5'd2, 1'b0, 1'b0, 2'b11, 1'b1}) $display("FAIL div_zero: got busy=%b obs=%h want busy=0 obs=%h", busy, obs, {8'h05, 5'd2, 1'b0, 1'b0, 2'b11, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
      send(POP, 8'h00);

      send(PUSH, 8'hFF);
      send(PUSH, 8'h80);
      send(DIV, 8'h00);
      wait_div(lat);
      check_cnt++;
      if (obs !== {8'h80, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1}) $display("FAIL div_min_m1: got %h want %h", obs, {8'h80, 5'd1, 1'b0, 1'b1, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_boundary();
      for (int i = 0; i < DEPTH; i++) send(PUSH, 8'(i));
      check_cnt++;
      if ({full, empty, count, tos} !== {1'b1, 1'b0, 5'd16, 8'h0F}) $display("FAIL fill: got f=%b e=%b cnt=%0d tos=%h want f=1 e=0 cnt=16 tos=0f", full, empty, count, tos);
      else pass_cnt++;
      send(PUSH, 8'hAA);
      check_cnt++;
      if ({full, obs} !== {1'b1, 8'h0F, 5'd16, 1'b0, 1'b0, 2'b10, 1'b1}) $display("FAIL push_full: got f=%b obs=%h want f=1 obs=%h", full, obs, {8'h0F, 5'd16, 1'b0, 1'b0, 2'b10, 1'b1});
      else pass_cnt++;
      for (int i = 0; i < DEPTH; i++) send(POP, 8'h00);
      check_cnt++;
      if ({empty, count, err} !== {1'b1, 5'd0, 2'b00}) $display("FAIL drain: got e=%b cnt=%0d err=%0d want e=1 cnt=0 err=0", empty, count, err);
      else pass_cnt++;
      send(ADD, 8'h00);
      check_cnt++;
      if (obs !== {8'h00, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1}) $display("FAIL add_empty: got %h want %h", obs, {8'h00, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1});
      else pass_cnt++;
      send(NOP, 8'h00);
      check_cnt++;
      if ({err, done, count} !== {2'b01, 1'b0, 5'd0}) $display("FAIL nop_hold: got err=%0d done=%b cnt=%0d want err=1 done=0 cnt=0", err, done, count);
      else pass_cnt++;
      send(PUSH, 8'h33);
      check_cnt++;
      if (obs !== {8'h33, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1}) $display("FAIL err_clear: got %h want %h", obs, {8'h33, 5'd1, 1'b0, 1'b0, 2'b00, 1'b1});
      else pass_cnt++;
      send(POP, 8'h00);
   endtask

   task automatic test_reset_mid_div();
      int done_seen;
      send(PUSH, 8'h03);
      send(PUSH, 8'h09);
      send(DIV, 8'h00);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      check_cnt++;
      if ({count, busy, cmd_ready, done, err} !== {5'd0, 1'b0, 1'b1, 1'b0, 2'b00})
         $display("FAIL reset_mid_div: got cnt=%0d busy=%b rdy=%b done=%b err=%0d want 0 0 1 0 0", count, busy, cmd_ready, done, err);
      else pass_cnt++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 2 * WIDTH; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1 || count !== 5'd0) done_seen++;
      end
      $display("post-reset idle window: %0d active cycles", done_seen);
      check_cnt++;
      if (done_seen !== 0) $display("FAIL reset_no_wb: got %0d cycles with done/busy/count activity want 0", done_seen);
      else pass_cnt++;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_swap();
      test_div();
      test_boundary();
      test_reset_mid_div();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
